// File: rtl/ball_game_core.sv
`timescale 1ns/1ps
// Frame-rate paddle-and-ball engine: paddle motion, ball physics, BCD score,
// lives and the IDLE/SERVE/PLAY/MISS/OVER game-state machine.
module ball_game_core #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int COORD_W      = 10,
  parameter int PADDLE_W     = 80,
  parameter int PADDLE_Y     = 460,
  parameter int BALL_SIZE    = 8,
  parameter int LIVES        = 3,
  parameter int SCORE_DIGITS = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame_tick,
  input  logic                      btn_left,
  input  logic                      btn_right,
  input  logic                      btn_start,
  input  logic [3:0]                bar_move_speed,
  input  logic [1:0]                ball_speed,
  output logic [COORD_W-1:0]        paddle_x,
  output logic [COORD_W-1:0]        ball_x,
  output logic [COORD_W-1:0]        ball_y,
  output logic [4*SCORE_DIGITS-1:0] score_bcd,
  output logic [3:0]                lives_left,
  output logic [2:0]                state,
  output logic                      hit_pulse,
  output logic                      lose_pulse,
  output logic                      freeze,
  output logic                      game_over
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_SERVE = 3'd1, S_PLAY = 3'd2, S_MISS = 3'd3, S_OVER = 3'd4
  } state_t;

  localparam int CW = COORD_W + 1;
  localparam int SW = 4 * SCORE_DIGITS;
  localparam logic [CW-1:0] PX_MAX  = CW'(H_ACTIVE - PADDLE_W);
  localparam logic [CW-1:0] PX_RST  = CW'((H_ACTIVE - PADDLE_W) / 2);
  localparam logic [CW-1:0] ATTACH  = CW'(PADDLE_W / 2 - BALL_SIZE / 2);
  localparam logic [CW-1:0] BX_MAX  = CW'(H_ACTIVE - BALL_SIZE);
  localparam logic [CW-1:0] BY_MAX  = CW'(V_ACTIVE - BALL_SIZE);
  localparam logic [CW-1:0] BY_REST = CW'(PADDLE_Y - BALL_SIZE);
  localparam logic [CW-1:0] PAD_Y   = CW'(PADDLE_Y);
  localparam logic [CW-1:0] PAD_W   = CW'(PADDLE_W);
  localparam logic [CW-1:0] BSZ     = CW'(BALL_SIZE);
  localparam logic [3:0]    LIVES_INIT = 4'(LIVES);

  state_t               state_q, state_d;
  logic [COORD_W-1:0]   paddle_q, paddle_d, ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic                 dx_pos_q, dx_pos_d, dy_down_q, dy_down_d;
  logic [SW-1:0]        score_q, score_d, score_inc;
  logic [3:0]           lives_q, lives_d;
  logic                 start_req_q, start_req_d, btn_start_q;
  logic                 hit_q, hit_d, lose_q, lose_d;
  logic                 carry, all_nines, hit_cond;
  logic [CW-1:0]        step, v, px_w, bx_w, by_w, paddle_mv;

  // All geometry is done one bit wider than the coordinates so sums never wrap.
  assign step = CW'(bar_move_speed) + CW'(1);
  assign v    = CW'(ball_speed) + CW'(1);
  assign px_w = {1'b0, paddle_q};
  assign bx_w = {1'b0, ball_x_q};
  assign by_w = {1'b0, ball_y_q};

  always_comb begin
    paddle_mv = px_w;
    if (btn_left && !btn_right)
      paddle_mv = (px_w < step) ? '0 : px_w - step;
    else if (btn_right && !btn_left)
      paddle_mv = (px_w + step >= PX_MAX) ? PX_MAX : px_w + step;
  end

  assign hit_cond = dy_down_q && (by_w + BSZ <= PAD_Y) && (by_w + BSZ + v >= PAD_Y) &&
                    (bx_w + BSZ > px_w) && (bx_w < px_w + PAD_W);

  // Ripple BCD increment; an all-nines score saturates instead of rolling over.
  always_comb begin
    score_inc = score_q;
    carry     = 1'b1;
    all_nines = 1'b1;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      if (score_q[4*i +: 4] != 4'd9) all_nines = 1'b0;
      if (carry) begin
        if (score_q[4*i +: 4] == 4'd9) begin
          score_inc[4*i +: 4] = 4'd0;
        end else begin
          score_inc[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    if (all_nines) score_inc = score_q;
  end

  always_comb begin
    state_d     = state_q;
    paddle_d    = paddle_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    dx_pos_d    = dx_pos_q;
    dy_down_d   = dy_down_q;
    score_d     = score_q;
    lives_d     = lives_q;
    hit_d       = 1'b0;
    lose_d      = 1'b0;
    start_req_d = (start_req_q && !frame_tick) || (btn_start && !btn_start_q);
    if (frame_tick) begin
      case (state_q)
        S_IDLE: if (start_req_q) state_d = S_SERVE;
        S_SERVE: begin
          paddle_d = COORD_W'(paddle_mv);
          ball_x_d = COORD_W'(paddle_mv + ATTACH);
          ball_y_d = COORD_W'(BY_REST);
          if (start_req_q) state_d = S_PLAY;
        end
        S_PLAY: begin
          paddle_d = COORD_W'(paddle_mv);
          if (!dx_pos_q && bx_w <= v) begin
            ball_x_d = '0;
            dx_pos_d = 1'b1;
          end else if (dx_pos_q && bx_w + v >= BX_MAX) begin
            ball_x_d = COORD_W'(BX_MAX);
            dx_pos_d = 1'b0;
          end else begin
            ball_x_d = dx_pos_q ? COORD_W'(bx_w + v) : COORD_W'(bx_w - v);
          end
          if (!dy_down_q && by_w <= v) begin
            ball_y_d  = '0;
            dy_down_d = 1'b1;
          end else if (hit_cond) begin
            ball_y_d  = COORD_W'(BY_REST);
            dy_down_d = 1'b0;
            score_d   = score_inc;
            hit_d     = 1'b1;
          end else if (dy_down_q && by_w + v >= BY_MAX) begin
            ball_y_d = COORD_W'(BY_MAX);
            lives_d  = lives_q - 4'd1;
            lose_d   = 1'b1;
            state_d  = S_MISS;
          end else begin
            ball_y_d = dy_down_q ? COORD_W'(by_w + v) : COORD_W'(by_w - v);
          end
        end
        S_MISS: begin
          if (lives_q == 4'd0) begin
            state_d = S_OVER;
          end else begin
            state_d   = S_SERVE;
            ball_x_d  = COORD_W'(px_w + ATTACH);
            ball_y_d  = COORD_W'(BY_REST);
            dx_pos_d  = 1'b1;
            dy_down_d = 1'b0;
          end
        end
        S_OVER: begin
          if (start_req_q) begin
            state_d   = S_SERVE;
            score_d   = '0;
            lives_d   = LIVES_INIT;
            ball_x_d  = COORD_W'(px_w + ATTACH);
            ball_y_d  = COORD_W'(BY_REST);
            dx_pos_d  = 1'b1;
            dy_down_d = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      paddle_q    <= COORD_W'(PX_RST);
      ball_x_q    <= COORD_W'(PX_RST + ATTACH);
      ball_y_q    <= COORD_W'(BY_REST);
      dx_pos_q    <= 1'b1;
      dy_down_q   <= 1'b0;
      score_q     <= '0;
      lives_q     <= LIVES_INIT;
      start_req_q <= 1'b0;
      btn_start_q <= 1'b0;
      hit_q       <= 1'b0;
      lose_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      paddle_q    <= paddle_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      dx_pos_q    <= dx_pos_d;
      dy_down_q   <= dy_down_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      start_req_q <= start_req_d;
      btn_start_q <= btn_start;
      hit_q       <= hit_d;
      lose_q      <= lose_d;
    end
  end

  assign paddle_x   = paddle_q;
  assign ball_x     = ball_x_q;
  assign ball_y     = ball_y_q;
  assign score_bcd  = score_q;
  assign lives_left = lives_q;
  assign state      = state_q;
  assign hit_pulse  = hit_q;
  assign lose_pulse = lose_q;
  assign freeze     = (state_q != S_PLAY);
  assign game_over  = (state_q == S_OVER);
endmodule

// File: tb/tb_ball_game_core.sv
`timescale 1ns/1ps
// Bench for ball_game_core: a behavioural game model feeds a scoreboard that is
// compared against the DUT every clock, plus directed reset/clamp/BCD checks.
module tb_ball_game_core;
  localparam int H = 640, V = 480, PW = 80, PY = 460, BS = 8, NL = 3;

  logic       clk = 1'b0, rst = 1'b0, frame_tick = 1'b0;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_start = 1'b0;
  logic [3:0] bar_move_speed = 4'd0;
  logic [1:0] ball_speed = 2'd0;
  logic [9:0] paddle_x, ball_x, ball_y;
  logic [7:0] score_bcd;
  logic [3:0] lives_left;
  logic [2:0] state;
  logic       hit_pulse, lose_pulse, freeze, game_over;

  ball_game_core dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .btn_left(btn_left), .btn_right(btn_right), .btn_start(btn_start),
    .bar_move_speed(bar_move_speed), .ball_speed(ball_speed),
    .paddle_x(paddle_x), .ball_x(ball_x), .ball_y(ball_y),
    .score_bcd(score_bcd), .lives_left(lives_left), .state(state),
    .hit_pulse(hit_pulse), .lose_pulse(lose_pulse),
    .freeze(freeze), .game_over(game_over)
  );

  always #5 clk = ~clk;

  typedef struct { int st, px, bx, by, score, lives, hit, lose; } exp_t;
  exp_t sb_q[$];

  int m_st, m_px, m_bx, m_by, m_dx, m_dy, m_score, m_lives, m_sreq, m_bprev, m_hit, m_lose;
  int checks = 0, failures = 0;
  int ctl_mode = 0;
  int last_hit, last_lose;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int bcd(input int s);
    return (s / 10) * 16 + (s % 10);
  endfunction

  task automatic model_reset();
    m_st = 0; m_px = (H - PW) / 2; m_bx = m_px + PW/2 - BS/2; m_by = PY - BS;
    m_dx = 1; m_dy = -1; m_score = 0; m_lives = NL; m_sreq = 0; m_bprev = 0;
    m_hit = 0; m_lose = 0;
  endtask

  task automatic attach(input int px);
    m_bx = px + PW/2 - BS/2; m_by = PY - BS; m_dx = 1; m_dy = -1;
  endtask

  // One clock of the reference game, using the inputs currently driven.
  task automatic model_step();
    int step, v, npx, opx, ob, edge_s, tk;
    step = int'(bar_move_speed) + 1;
    v = int'(ball_speed) + 1;
    tk = int'(frame_tick);
    edge_s = (btn_start && m_bprev == 0) ? 1 : 0;
    m_hit = 0; m_lose = 0;
    if (tk != 0) begin
      npx = m_px;
      if (btn_left && !btn_right) npx = (m_px - step < 0) ? 0 : m_px - step;
      else if (btn_right && !btn_left) npx = (m_px + step > H - PW) ? H - PW : m_px + step;
      opx = m_px; ob = m_bx;
      case (m_st)
        0: if (m_sreq != 0) m_st = 1;
        1: begin
          m_px = npx; m_bx = npx + PW/2 - BS/2; m_by = PY - BS;
          if (m_sreq != 0) m_st = 2;
        end
        2: begin
          m_px = npx;
          if (m_dx < 0 && m_bx <= v) begin m_bx = 0; m_dx = 1; end
          else if (m_dx > 0 && m_bx + v >= H - BS) begin m_bx = H - BS; m_dx = -1; end
          else m_bx = m_bx + m_dx * v;
          if (m_dy < 0 && m_by <= v) begin m_by = 0; m_dy = 1; end
          else if (m_dy > 0 && m_by + BS <= PY && m_by + BS + v >= PY &&
                   ob + BS > opx && ob < opx + PW) begin
            m_by = PY - BS; m_dy = -1; m_hit = 1;
            if (m_score < 99) m_score++;
          end else if (m_dy > 0 && m_by + v >= V - BS) begin
            m_by = V - BS; m_lives--; m_lose = 1; m_st = 3;
          end else m_by = m_by + m_dy * v;
        end
        3: if (m_lives == 0) m_st = 4; else begin m_st = 1; attach(m_px); end
        4: if (m_sreq != 0) begin m_st = 1; m_score = 0; m_lives = NL; attach(m_px); end
        default: ;
      endcase
    end
    m_sreq = ((m_sreq != 0 && tk == 0) || edge_s != 0) ? 1 : 0;
    m_bprev = int'(btn_start);
  endtask

  task automatic cyc(input bit tk);
    exp_t e;
    @(negedge clk);
    frame_tick = tk;
    model_step();
    sb_q.push_back('{m_st, m_px, m_bx, m_by, m_score, m_lives, m_hit, m_lose});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("state", 32'(state), 32'(e.st));
    chk("paddle_x", 32'(paddle_x), 32'(e.px));
    chk("ball_x", 32'(ball_x), 32'(e.bx));
    chk("ball_y", 32'(ball_y), 32'(e.by));
    chk("score", 32'(score_bcd), 32'(bcd(e.score)));
    chk("lives", 32'(lives_left), 32'(e.lives));
    chk("hit_pulse", 32'(hit_pulse), 32'(e.hit));
    chk("lose_pulse", 32'(lose_pulse), 32'(e.lose));
    chk("freeze", 32'(freeze), (e.st != 2) ? 32'd1 : 32'd0);
    chk("game_over", 32'(game_over), (e.st == 4) ? 32'd1 : 32'd0);
  endtask

  task automatic tick();
    if (ctl_mode == 1) begin
      btn_left  = (m_bx + BS/2 < m_px + PW/2 - 8);
      btn_right = (m_bx + BS/2 > m_px + PW/2 + 8);
    end else if (ctl_mode == 2) begin
      btn_right = (m_bx + BS/2 < H/2);
      btn_left  = !btn_right;
    end
    cyc(1'b1);
    last_hit = m_hit; last_lose = m_lose;
    cyc(1'b0);
  endtask

  task automatic press_start();
    btn_start = 1'b1; cyc(1'b0);
    btn_start = 1'b0; cyc(1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_state"}, 32'(state), 32'd0);
    chk({tag, "_px"}, 32'(paddle_x), 32'd280);
    chk({tag, "_bx"}, 32'(ball_x), 32'd316);
    chk({tag, "_by"}, 32'(ball_y), 32'd452);
    chk({tag, "_score"}, 32'(score_bcd), 32'h00);
    chk({tag, "_lives"}, 32'(lives_left), 32'd3);
    chk({tag, "_freeze"}, 32'(freeze), 32'd1);
    chk({tag, "_over"}, 32'(game_over), 32'd0);
    chk({tag, "_hit"}, 32'(hit_pulse), 32'd0);
    chk({tag, "_lose"}, 32'(lose_pulse), 32'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, pre, sat_hits;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("rst");
    rst = 1'b1;

    // IDLE ignores paddle buttons; start then moves to SERVE.
    btn_right = 1'b1; tick(); btn_right = 1'b0;
    press_start(); tick();
    chk("serve_state", 32'(state), 32'd1);
    btn_left = 1'b1; btn_right = 1'b1; bar_move_speed = 4'd5; tick(); tick();
    btn_right = 1'b0;

    bar_move_speed = 4'd15;
    for (int k = 1; k <= 20; k++) begin
      tick();
      n = (280 - 16 * k < 0) ? 0 : 280 - 16 * k;
      chk("clamp_px", 32'(paddle_x), 32'(n));
      chk("clamp_bx", 32'(ball_x), 32'(n + 36));
    end
    btn_left = 1'b0;

    // Tracked rally up to and past score saturation.
    ball_speed = 2'(3);
    press_start(); tick();
    chk("play_state", 32'(state), 32'd2);
    ctl_mode = 1; n = 0; sat_hits = 0;
    while (sat_hits < 3 && n < 30000) begin
      if (m_score < 10) ball_speed = 2'($urandom_range(0, 3));
      else ball_speed = 2'd3;
      if (n == 50) press_start();
      pre = m_score;
      tick();
      if (last_hit != 0 && pre == 9) chk("bcd_carry", 32'(score_bcd), 32'h10);
      if (last_hit != 0 && pre == 99) begin
        chk("sat_score", 32'(score_bcd), 32'h99);
        sat_hits++;
      end
      n++;
    end
    if (n >= 30000) chk("rally_timeout", 32'd0, 32'd1);

    // Lose every life.
    ctl_mode = 2; n = 0;
    while (m_st != 4 && n < 8000) begin
      if (m_st == 1) press_start();
      tick();
      if (last_lose != 0) chk("miss_state", 32'(state), 32'd3);
      n++;
    end
    if (n >= 8000) chk("miss_timeout", 32'd0, 32'd1);
    chk("over_state", 32'(state), 32'd4);
    chk("over_flag", 32'(game_over), 32'd1);
    chk("over_lives", 32'(lives_left), 32'd0);
    tick();
    press_start(); tick();
    chk("restart_state", 32'(state), 32'd1);
    chk("restart_score", 32'(score_bcd), 32'h00);
    chk("restart_lives", 32'(lives_left), 32'd3);

    // Rally to a hit, then reset asynchronously between ticks.
    ball_speed = 2'd3; ctl_mode = 1;
    press_start(); tick();
    n = 0;
    while (m_score < 1 && n < 2000) begin tick(); n++; end
    if (n >= 2000) chk("hit_timeout", 32'd0, 32'd1);
    repeat (5) tick();
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check_reset_values("arst");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk) frame_tick = 1'b1;
      @(posedge clk) #1;
      chk("arst_hold_state", 32'(state), 32'd0);
      chk("arst_hold_pulses", 32'({hit_pulse, lose_pulse}), 32'd0);
      @(negedge clk) frame_tick = 1'b0;
    end
    ctl_mode = 0; btn_left = 1'b0; btn_right = 1'b0;
    sb_q.delete();
    model_reset();
    @(negedge clk) rst = 1'b1;
    tick(); tick();
    press_start(); tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
